// File: rtl/servo_move_sequencer_pkg.sv
// Shared types and step arithmetic for the servo move sequencer.
package servo_pkg;

    localparam int NUM_JOINTS = 4;

    typedef logic [1:0] joint_idx_t;
    typedef logic [7:0] angle_t;

    typedef enum logic {
        IDLE,
        RUN
    } seq_state_t;

    // 9-bit intermediates keep cur+step and cur-step from wrapping before the clamp.
    function automatic angle_t clamp_step(angle_t cur, angle_t tgt, angle_t step);
        logic [8:0] wide;
        angle_t     result;
        result = cur;
        if (cur < tgt) begin
            wide   = {1'b0, cur} + {1'b0, step};
            result = (wide > {1'b0, tgt}) ? tgt : wide[7:0];
        end else if (cur > tgt) begin
            wide   = {1'b0, cur} - {1'b0, step};
            result = (wide[8] || (wide < {1'b0, tgt})) ? tgt : wide[7:0];
        end
        return result;
    endfunction

endpackage

// File: rtl/servo_move_sequencer_tick_gen.sv
// Free-running divider producing a one-cycle step tick every STEP_DIV clocks.
module servo_tick_gen #(
    parameter int STEP_DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;

    logic [CW-1:0] count;

    assign tick = (count == CW'(STEP_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/servo_move_sequencer.sv
// Four-joint servo ramp controller with a round-robin shared step engine.
// Optional home input enabled by defining SERVO_SEQ_HOME_EN.
module servo_move_sequencer
    import servo_pkg::*;
#(
    parameter int STEP_DIV   = 50000,
    parameter int STEP_SIZE  = 2,
    parameter int MAX_ANGLE  = 180,
    parameter int HOME_ANGLE = 90
) (
    input  logic       clk,
    input  logic       rst_n,
`ifdef SERVO_SEQ_HOME_EN
    input  logic       home,
`endif
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_joint,
    input  logic [7:0] cmd_angle,
    output logic [7:0] angle1,
    output logic [7:0] angle2,
    output logic [7:0] angle3,
    output logic [7:0] angle4,
    output logic       busy,
    output logic [3:0] arrived
);

    localparam angle_t MAX_A  = angle_t'(MAX_ANGLE);
    localparam angle_t HOME_A = angle_t'(HOME_ANGLE);
    localparam angle_t STEP_A = angle_t'(STEP_SIZE);

    logic                  tick;
    logic                  accept;
    logic                  apply_home;
    angle_t                cmd_clamped;
    angle_t                angle_q  [NUM_JOINTS];
    angle_t                target_q [NUM_JOINTS];
    logic [NUM_JOINTS-1:0] mismatch;
    joint_idx_t            ptr;
    joint_idx_t            svc_idx;
    joint_idx_t            probe;
    logic                  found;
    angle_t                step_angle;
    seq_state_t            state;

    servo_tick_gen #(
        .STEP_DIV(STEP_DIV)
    ) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    // Commands are refused on tick cycles so targets never move under the step engine.
    assign cmd_ready   = ~tick;
    assign accept      = cmd_valid & cmd_ready;
    assign cmd_clamped = (cmd_angle > MAX_A) ? MAX_A : cmd_angle;

`ifdef SERVO_SEQ_HOME_EN
    assign apply_home = home & ~tick;
`else
    assign apply_home = 1'b0;
`endif

    assign angle1 = angle_q[0];
    assign angle2 = angle_q[1];
    assign angle3 = angle_q[2];
    assign angle4 = angle_q[3];

    always_comb begin
        for (int j = 0; j < NUM_JOINTS; j++) begin
            mismatch[j] = (angle_q[j] != target_q[j]);
        end
    end

    // Round-robin search starting at the pointer; first mismatching joint wins.
    always_comb begin
        found   = 1'b0;
        svc_idx = ptr;
        probe   = ptr;
        for (int i = 0; i < NUM_JOINTS; i++) begin
            probe = ptr + joint_idx_t'(i);
            if (!found && mismatch[probe]) begin
                found   = 1'b1;
                svc_idx = probe;
            end
        end
    end

    assign step_angle = clamp_step(angle_q[svc_idx], target_q[svc_idx], STEP_A);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < NUM_JOINTS; j++) begin
                angle_q[j]  <= HOME_A;
                target_q[j] <= HOME_A;
            end
            ptr     <= '0;
            state   <= IDLE;
            busy    <= 1'b0;
            arrived <= '0;
        end else begin
            arrived <= '0;

            if (apply_home) begin
                for (int j = 0; j < NUM_JOINTS; j++) begin
                    target_q[j] <= HOME_A;
                end
            end else if (accept) begin
                target_q[cmd_joint] <= cmd_clamped;
            end

            case (state)
                IDLE: begin
                    if (|mismatch) begin
                        state <= RUN;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (tick) begin
                        if (found) begin
                            angle_q[svc_idx] <= step_angle;
                            if (step_angle == target_q[svc_idx]) begin
                                arrived[svc_idx] <= 1'b1;
                            end
                            ptr <= svc_idx + 2'd1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
